// File: rtl/conv_kxk_seq.sv
// conv_kxk_seq: KxK FP16 sliding-window convolution over a column stream with one time-multiplexed MAC
module mulfp16 (
   input  logic [15:0] a_in,
   input  logic [15:0] b_in,
   output logic [15:0] c_out
);
   logic [11:0] ph;
   logic [6:0] e;
   always_comb begin
      ph = 12'(({12'd0, 1'b1, a_in[9:0]} * {12'd0, 1'b1, b_in[9:0]}) >> 10);
      e = {2'b00, a_in[14:10]} + {2'b00, b_in[14:10]} + {6'd0, ph[11]};
      c_out = (a_in[14:10] == 5'd0 || b_in[14:10] == 5'd0 || e <= 7'd15) ? 16'h0000
            : e >= 7'd46 ? {a_in[15] ^ b_in[15], 15'h7C00}
            : {a_in[15] ^ b_in[15], 5'(e - 7'd15), ph[11] ? ph[10:1] : ph[9:0]};
   end
endmodule

module addfp16 (
   input  logic [15:0] a,
   input  logic [15:0] b,
   output logic [15:0] sum
);
   logic [15:0] x, y;
   logic [14:0] mx, my, s;
   logic [3:0] p;
   logic [6:0] e;
   always_comb begin
      x = a[14:0] < b[14:0] ? b : a;
      y = a[14:0] < b[14:0] ? a : b;
      mx = x[14:10] == 5'd0 ? 15'd0 : {2'b01, x[9:0], 3'b000};
      my = y[14:10] == 5'd0 ? 15'd0 : {2'b01, y[9:0], 3'b000} >> (x[14:10] - y[14:10]);
      s = x[15] == y[15] ? mx + my : mx - my;
      p = 4'd0;
      for (int i = 0; i < 15; i++) p = s[i] ? 4'(i) : p;
      e = {2'b00, x[14:10]} + {3'b000, p};
      sum = (s == 15'd0 || e <= 7'd13) ? 16'h0000
          : e >= 7'd44 ? {x[15], 15'h7C00}
          : {x[15], 5'(e - 7'd13), 10'((s << (4'd14 - p)) >> 4)};
   end
endmodule

module conv_kxk_seq #(
   parameter int DATA_WIDTH  = 16,
   parameter int KERNEL_SIZE = 3,
   parameter int STRIDE      = 1,
   parameter int RELU        = 0
) (
   input  logic                              clk,
   input  logic                              rst_n,
   input  logic [KERNEL_SIZE*DATA_WIDTH-1:0] data_in,
   input  logic                              in_valid,
   output logic                              in_ready,
   input  logic                              kernel_load,
   input  logic                              sof,
   input  logic [DATA_WIDTH-1:0]             bias,
   output logic [DATA_WIDTH-1:0]             out_data,
   output logic                              out_valid,
   input  logic                              out_ready
);
   localparam int K = KERNEL_SIZE;
   localparam int IW = $clog2(K);
   localparam logic [IW-1:0] KM1 = IW'(K - 1);
   localparam logic [2:0] KW = 3'(K);
   localparam logic [2:0] SM1 = 3'(STRIDE - 1);
   typedef enum logic [1:0] {S_IN, S_MAC, S_OUT} state_t;
   state_t state, state_d;
   logic [DATA_WIDTH-1:0] kern [K][K];
   logic [DATA_WIDTH-1:0] win [K][K];
   logic [DATA_WIDTH-1:0] acc, prod, sum;
   logic [2:0] col_cnt, stride_cnt, col_d, stride_base;
   logic [IW-1:0] r, c;
   logic drain, fire_k, fire_img, trigger;

   mulfp16 u_mul (.a_in(win[r][c]), .b_in(kern[r][c]), .c_out(prod));
   addfp16 u_add (.a(acc), .b(prod), .sum(sum));

   assign in_ready = state == S_IN;
   assign out_valid = state == S_OUT;
   assign out_data = (RELU != 0 && acc[DATA_WIDTH-1]) ? '0 : acc;

   always_comb begin
      fire_k = state == S_IN && in_valid && kernel_load;
      fire_img = state == S_IN && in_valid && !kernel_load;
      stride_base = sof ? 3'd0 : stride_cnt;
      col_d = sof ? 3'd1 : col_cnt == KW ? KW : col_cnt + 3'd1;
      trigger = fire_img && col_d == KW && stride_base == 3'd0;
      state_d = trigger ? S_MAC
              : (state == S_MAC && drain) ? S_OUT
              : (state == S_OUT && out_ready) ? S_IN
              : state;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) state <= S_IN;
      else state <= state_d;
   end

   // drain adds one settling cycle after the final MAC before the result is presented
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < K; i++)
            for (int j = 0; j < K; j++) begin
               kern[i][j] <= '0;
               win[i][j] <= '0;
            end
         acc <= '0;
         col_cnt <= '0;
         stride_cnt <= '0;
         r <= '0;
         c <= '0;
         drain <= 1'b0;
      end else begin
         if (fire_k)
            for (int i = 0; i < K; i++) begin
               for (int j = 0; j < K - 1; j++) kern[i][j] <= kern[i][j+1];
               kern[i][K-1] <= data_in[i*DATA_WIDTH +: DATA_WIDTH];
            end
         if (fire_img) begin
            for (int i = 0; i < K; i++) begin
               for (int j = 0; j < K - 1; j++) win[i][j] <= win[i][j+1];
               win[i][K-1] <= data_in[i*DATA_WIDTH +: DATA_WIDTH];
            end
            col_cnt <= col_d;
            stride_cnt <= col_d != KW ? stride_base : stride_base == SM1 ? 3'd0 : stride_base + 3'd1;
         end
         if (trigger) begin
            acc <= bias;
            r <= '0;
            c <= '0;
            drain <= 1'b0;
         end
         if (state == S_MAC && !drain) begin
            acc <= sum;
            c <= c == KM1 ? '0 : c + 1'b1;
            r <= (c == KM1 && r != KM1) ? r + 1'b1 : r;
            drain <= c == KM1 && r == KM1;
         end
      end
   end
endmodule

// File: tb/tb_conv_kxk_seq.sv
// tb_conv_kxk_seq: directed vectors for conv_kxk_seq (K=3) across ReLU and stride variants
module tb_conv_kxk_seq;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic [47:0] din [3];
   logic iv [3], kl [3], sf [3], ordy [3], ir [3], ov [3];
   logic [15:0] bs [3], od [3];
   int errors = 0;
   int checks = 0;

   typedef struct {
      int d;
      logic lk;
      logic [15:0] k, i, b, e;
      int hold;
   } vec_t;
   vec_t vt [9];
   logic [15:0] sv [10];
   logic st [10];
   logic [15:0] se [10];

   always #5 clk = ~clk;

   conv_kxk_seq #(.KERNEL_SIZE(3), .STRIDE(1), .RELU(0)) u0 (
      .clk(clk), .rst_n(rst_n), .data_in(din[0]), .in_valid(iv[0]), .in_ready(ir[0]),
      .kernel_load(kl[0]), .sof(sf[0]), .bias(bs[0]), .out_data(od[0]), .out_valid(ov[0]), .out_ready(ordy[0]));
   conv_kxk_seq #(.KERNEL_SIZE(3), .STRIDE(1), .RELU(1)) u1 (
      .clk(clk), .rst_n(rst_n), .data_in(din[1]), .in_valid(iv[1]), .in_ready(ir[1]),
      .kernel_load(kl[1]), .sof(sf[1]), .bias(bs[1]), .out_data(od[1]), .out_valid(ov[1]), .out_ready(ordy[1]));
   conv_kxk_seq #(.KERNEL_SIZE(3), .STRIDE(2), .RELU(0)) u2 (
      .clk(clk), .rst_n(rst_n), .data_in(din[2]), .in_valid(iv[2]), .in_ready(ir[2]),
      .kernel_load(kl[2]), .sof(sf[2]), .bias(bs[2]), .out_data(od[2]), .out_valid(ov[2]), .out_ready(ordy[2]));

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic beat(input int d, input logic k, input logic s, input logic [15:0] v, input logic [15:0] b);
      int n = 0;
      while (!ir[d] && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      if (n == 100) check("beat in_ready", 16'(ir[d]), 16'd1);
      din[d] = {v, v, v};
      kl[d] = k;
      sf[d] = s;
      bs[d] = b;
      iv[d] = 1'b1;
      @(posedge clk); #1;
      iv[d] = 1'b0;
      kl[d] = 1'b0;
      sf[d] = 1'b0;
   endtask

   // feeds random beats while the DUT is busy; none of them may be taken
   task automatic junk(input int d);
      iv[d] = 1'b1;
      kl[d] = 1'($urandom);
      sf[d] = 1'($urandom);
      din[d] = {16'($urandom), 16'($urandom), 16'($urandom)};
      bs[d] = 16'($urandom);
   endtask

   task automatic wait_out(input int d, input string name, input logic [15:0] exp, input int hold);
      int n = 0;
      logic ok = 1'b1;
      ordy[d] = 1'b0;
      while (!ov[d] && n < 60) begin
         junk(d);
         @(posedge clk); #1;
         n++;
      end
      check({name, " latency"}, 16'(n), 16'd10);
      check({name, " data"}, od[d], exp);
      for (int i = 0; i < hold; i++) begin
         junk(d);
         @(posedge clk); #1;
         if (od[d] !== exp || ov[d] !== 1'b1 || ir[d] !== 1'b0) ok = 1'b0;
      end
      if (hold > 0) check({name, " held stable"}, 16'(ok), 16'd1);
      iv[d] = 1'b0;
      ordy[d] = 1'b1;
      @(posedge clk); #1;
      ordy[d] = 1'b0;
      check({name, " in_ready after transfer"}, 16'(ir[d]), 16'd1);
      check({name, " single transfer"}, 16'(ov[d]), 16'd0);
   endtask

   task automatic window(input int d, input logic lk, input logic [15:0] k, input logic [15:0] i, input logic [15:0] b);
      if (lk) for (int j = 0; j < 3; j++) beat(d, 1'b1, 1'b1, k, 16'hFFFF);
      beat(d, 1'b0, 1'b1, i, 16'h7BFF);
      beat(d, 1'b0, 1'b0, i, 16'h7BFF);
      beat(d, 1'b0, 1'b0, i, b);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1);
   end

   initial begin
      logic ok;
      vt[0] = '{0, 1'b1, 16'h3C00, 16'h3C00, 16'h0000, 16'h4880, 0};
      vt[1] = '{0, 1'b0, 16'h3C00, 16'h3C00, 16'hC900, 16'hBC00, 0};
      vt[2] = '{1, 1'b1, 16'h3C00, 16'h3C00, 16'hC900, 16'h0000, 0};
      vt[3] = '{1, 1'b0, 16'h3C00, 16'h3C00, 16'h0000, 16'h4880, 0};
      vt[4] = '{0, 1'b1, 16'h4000, 16'h3C00, 16'h0000, 16'h4C80, 20};
      vt[5] = '{0, 1'b0, 16'h4000, 16'h4000, 16'h0000, 16'h5080, 0};
      vt[6] = '{0, 1'b1, 16'h3800, 16'h4000, 16'h3C00, 16'h4900, 0};
      vt[7] = '{0, 1'b0, 16'h3800, 16'h4400, 16'h0000, 16'h4C80, 0};
      vt[8] = '{0, 1'b1, 16'h0000, 16'h3C00, 16'h4200, 16'h4200, 0};
      sv = '{16'h3C00, 16'h4000, 16'h4200, 16'h4400, 16'h4500, 16'h4600, 16'h4700, 16'h3C00, 16'h3C00, 16'h3C00};
      st = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
      se = '{16'h0, 16'h0, 16'h4C80, 16'h0, 16'h5080, 16'h0, 16'h52C0, 16'h0, 16'h0, 16'h4880};
      for (int d = 0; d < 3; d++) begin
         din[d] = '0; iv[d] = 1'b0; kl[d] = 1'b0; sf[d] = 1'b0; ordy[d] = 1'b0; bs[d] = '0;
      end
      repeat (3) @(posedge clk);
      #1;
      for (int d = 0; d < 3; d++) begin
         check($sformatf("reset out_valid u%0d", d), 16'(ov[d]), 16'd0);
         check($sformatf("reset out_data u%0d", d), od[d], 16'h0000);
      end
      rst_n = 1'b1;
      for (int d = 0; d < 3; d++) check($sformatf("in_ready after reset u%0d", d), 16'(ir[d]), 16'd1);

      for (int v = 0; v < 9; v++) begin
         window(vt[v].d, vt[v].lk, vt[v].k, vt[v].i, vt[v].b);
         wait_out(vt[v].d, $sformatf("vec%0d", v), vt[v].e, vt[v].hold);
      end

      for (int j = 0; j < 3; j++) beat(2, 1'b1, 1'b0, 16'h3C00, 16'h0000);
      for (int j = 0; j < 10; j++) begin
         beat(2, 1'b0, j == 0 || j == 7, sv[j], 16'h0000);
         if (st[j]) wait_out(2, $sformatf("stride beat%0d", j + 1), se[j], 0);
         else begin
            check($sformatf("stride beat%0d no output", j + 1), 16'(ov[2]), 16'd0);
            check($sformatf("stride beat%0d no start", j + 1), 16'(ir[2]), 16'd1);
         end
      end

      window(0, 1'b1, 16'h4000, 16'h3C00, 16'h0000);
      repeat (4) @(posedge clk);
      #1;
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      check("abort in_ready", 16'(ir[0]), 16'd1);
      ok = 1'b1;
      for (int i = 0; i < 15; i++) begin
         @(posedge clk); #1;
         if (ov[0] !== 1'b0) ok = 1'b0;
      end
      check("abort no out_valid", 16'(ok), 16'd1);
      window(0, 1'b0, 16'h0000, 16'h3C00, 16'h0000);
      wait_out(0, "post-reset zero kernel", 16'h0000, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
